// File: rtl/imem_fetch_pkg.sv
// Shared types and helpers for the instruction-fetch sequencer.
package imem_fetch_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] pc;
      logic        err;
   } fetch_entry_t;

   // Substituted for imem data on faulting fetches (addi x0,x0,0).
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   // A fetch faults when the PC is not word aligned or lies past the end of imem.
   function automatic logic fetch_fault(input logic [31:0] pc, input logic [31:0] limit);
      return (pc[1:0] != 2'b00) || (pc >= limit);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush has priority over push.
module fetch_fifo
   import imem_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  fetch_entry_t           wr_entry,
   output fetch_entry_t           rd_entry,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]            count_q, count_d;
   logic                     do_pop;

   assign do_pop   = pop & ~empty;
   assign rd_entry = mem_q[rd_ptr_q];
   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;

   // Next-state for storage, pointers and occupancy; pointers wrap at DEPTH.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(do_pop);
      end
   end

   // FIFO state registers; storage is cleared so empty outputs read as zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, fills a prefetch FIFO from
// combinational imem, and hands entries to decode with valid/ready.
module imem_fetch_ctrl
   import imem_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          DEPTH      = 2,
   parameter int          IMEM_WORDS = 2048
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] o_imem_addr,
   input  logic [31:0] i_imem_data,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_halt,
   input  logic        i_dec_ready,
   output logic        o_inst_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_pc,
   output logic        o_inst_err,
   output logic        o_halted
);

   localparam int          CW         = $clog2(DEPTH) + 1;
   localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * 4);

   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;

   fetch_entry_t  wr_entry, rd_entry;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          pop, push, can_push, cur_err;

   assign cur_err  = fetch_fault(fetch_pc_q, IMEM_LIMIT);
   assign pop      = ~fifo_empty & i_dec_ready;
   // A full FIFO still takes a word when the head leaves this cycle.
   assign can_push = ~fifo_full | pop;
   assign push     = (state_q == RUN) & ~i_redirect_valid & ~i_halt & can_push;

   assign wr_entry.data = cur_err ? NOP_INSN : i_imem_data;
   assign wr_entry.pc   = fetch_pc_q;
   assign wr_entry.err  = cur_err;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .flush    (i_redirect_valid),
      .wr_entry (wr_entry),
      .rd_entry (rd_entry),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // Sequencer next state and fetch PC: redirect wins over halt, halt over fetch.
   // A faulting fetch parks the PC on the bad address and halts.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      if (i_redirect_valid) begin
         state_d    = RUN;
         fetch_pc_d = i_redirect_pc;
      end else begin
         unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
               if (i_halt) begin
                  state_d = HALT;
               end else if (push) begin
                  if (cur_err) state_d = HALT;
                  else         fetch_pc_d = fetch_pc_q + 32'd4;
               end
            end
            HALT: state_d = HALT;
            default: state_d = BOOT;
         endcase
      end
   end

   // State and fetch PC registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   assign o_imem_addr  = fetch_pc_q;
   assign o_inst_valid = (fifo_count != '0);
   assign o_inst       = rd_entry.data;
   assign o_inst_pc    = rd_entry.pc;
   assign o_inst_err   = rd_entry.err;
   assign o_halted     = (state_q == HALT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl; imem modelled as word = {16'hC0DE, addr[15:0]}.
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] o_imem_addr;
   logic [31:0] i_imem_data;
   logic        i_redirect_valid = 1'b0;
   logic [31:0] i_redirect_pc = '0;
   logic        i_halt = 1'b0;
   logic        i_dec_ready = 1'b0;
   logic        o_inst_valid;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
   logic        o_inst_err;
   logic        o_halted;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign i_imem_data = {16'hC0DE, o_imem_addr[15:0]};

   imem_fetch_ctrl #(
      .RESET_PC   (32'h0000_0000),
      .DEPTH      (2),
      .IMEM_WORDS (2048)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .o_imem_addr      (o_imem_addr),
      .i_imem_data      (i_imem_data),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_pc    (i_redirect_pc),
      .i_halt           (i_halt),
      .i_dec_ready      (i_dec_ready),
      .o_inst_valid     (o_inst_valid),
      .o_inst           (o_inst),
      .o_inst_pc        (o_inst_pc),
      .o_inst_err       (o_inst_err),
      .o_halted         (o_halted)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic head(input string tag, input logic [31:0] inst, input logic [31:0] pc, input logic err);
      chk({tag, ".valid"}, {31'd0, o_inst_valid}, 32'd1);
      chk({tag, ".inst"}, o_inst, inst);
      chk({tag, ".pc"}, o_inst_pc, pc);
      chk({tag, ".err"}, {31'd0, o_inst_err}, {31'd0, err});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      step(); step();
      chk("rst.valid", {31'd0, o_inst_valid}, 32'd0);
      chk("rst.addr", o_imem_addr, 32'h0);
      chk("rst.inst", o_inst, 32'h0);
      chk("rst.pc", o_inst_pc, 32'h0);
      chk("rst.err", {31'd0, o_inst_err}, 32'd0);
      chk("rst.halted", {31'd0, o_halted}, 32'd0);

      // streaming after reset release
      rst_n = 1'b1; i_dec_ready = 1'b1;
      step();
      chk("boot.valid", {31'd0, o_inst_valid}, 32'd0);
      chk("boot.addr", o_imem_addr, 32'h0);
      step(); head("strm0", 32'hC0DE_0000, 32'h0, 1'b0);
      step(); head("strm1", 32'hC0DE_0004, 32'h4, 1'b0);
      step(); head("strm2", 32'hC0DE_0008, 32'h8, 1'b0);
      step(); head("strm3", 32'hC0DE_000C, 32'hC, 1'b0);

      // decode stall fills the FIFO and freezes the fetch address
      rst_n = 1'b0; i_dec_ready = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      step(); head("stall0", 32'hC0DE_0000, 32'h0, 1'b0);
      chk("stall0.addr", o_imem_addr, 32'h4);
      for (int i = 0; i < 5; i++) begin
         step();
         head("stallN", 32'hC0DE_0000, 32'h0, 1'b0);
         chk("stallN.addr", o_imem_addr, 32'h8);
      end
      i_dec_ready = 1'b1;
      step(); head("drain1", 32'hC0DE_0004, 32'h4, 1'b0);
      step(); head("drain2", 32'hC0DE_0008, 32'h8, 1'b0);
      step(); head("drain3", 32'hC0DE_000C, 32'hC, 1'b0);
      chk("drain3.addr", o_imem_addr, 32'h14);

      // redirect to 0x40 on a full FIFO, same cycle as a pop
      i_redirect_valid = 1'b1; i_redirect_pc = 32'h40;
      step();
      i_redirect_valid = 1'b0;
      chk("redir.valid", {31'd0, o_inst_valid}, 32'd0);
      chk("redir.addr", o_imem_addr, 32'h40);
      step(); head("redir0", 32'hC0DE_0040, 32'h40, 1'b0);
      step(); head("redir1", 32'hC0DE_0044, 32'h44, 1'b0);

      // misaligned redirect target
      i_dec_ready = 1'b0; i_redirect_valid = 1'b1; i_redirect_pc = 32'h42;
      step();
      i_redirect_valid = 1'b0;
      chk("mis.valid0", {31'd0, o_inst_valid}, 32'd0);
      chk("mis.halted0", {31'd0, o_halted}, 32'd0);
      step(); head("mis", 32'h0000_0013, 32'h42, 1'b1);
      chk("mis.halted", {31'd0, o_halted}, 32'd1);
      chk("mis.addr", o_imem_addr, 32'h42);
      i_dec_ready = 1'b1;
      step();
      chk("mis.gone", {31'd0, o_inst_valid}, 32'd0);
      chk("mis.addr2", o_imem_addr, 32'h42);
      step();
      chk("mis.one", {31'd0, o_inst_valid}, 32'd0);

      // last in-range word, then the out-of-range boundary
      i_dec_ready = 1'b0; i_redirect_valid = 1'b1; i_redirect_pc = 32'h1FFC;
      step();
      i_redirect_valid = 1'b0;
      chk("oor.addr0", o_imem_addr, 32'h1FFC);
      chk("oor.halted0", {31'd0, o_halted}, 32'd0);
      step(); head("oor.last", 32'hC0DE_1FFC, 32'h1FFC, 1'b0);
      chk("oor.addr1", o_imem_addr, 32'h2000);
      chk("oor.halted1", {31'd0, o_halted}, 32'd0);
      step();
      chk("oor.halted2", {31'd0, o_halted}, 32'd1);
      chk("oor.addr2", o_imem_addr, 32'h2000);
      i_dec_ready = 1'b1;
      step(); head("oor.err", 32'h0000_0013, 32'h2000, 1'b1);
      step();
      chk("oor.gone", {31'd0, o_inst_valid}, 32'd0);
      chk("oor.halted3", {31'd0, o_halted}, 32'd1);

      // halt pulse with two entries buffered
      i_dec_ready = 1'b0; i_redirect_valid = 1'b1; i_redirect_pc = 32'h100;
      step();
      i_redirect_valid = 1'b0;
      step(); step();
      chk("hlt.addr0", o_imem_addr, 32'h108);
      i_halt = 1'b1;
      step();
      i_halt = 1'b0;
      chk("hlt.halted", {31'd0, o_halted}, 32'd1);
      head("hlt.h0", 32'hC0DE_0100, 32'h100, 1'b0);
      i_dec_ready = 1'b1;
      step(); head("hlt.h1", 32'hC0DE_0104, 32'h104, 1'b0);
      step();
      chk("hlt.empty", {31'd0, o_inst_valid}, 32'd0);
      step();
      chk("hlt.empty2", {31'd0, o_inst_valid}, 32'd0);
      chk("hlt.addr1", o_imem_addr, 32'h108);
      // redirect together with halt: redirect wins
      i_redirect_valid = 1'b1; i_redirect_pc = 32'h10; i_halt = 1'b1;
      step();
      i_redirect_valid = 1'b0; i_halt = 1'b0;
      chk("res.halted", {31'd0, o_halted}, 32'd0);
      chk("res.addr", o_imem_addr, 32'h10);
      step(); head("res0", 32'hC0DE_0010, 32'h10, 1'b0);
      step(); head("res1", 32'hC0DE_0014, 32'h14, 1'b0);

      // asynchronous reset between edges
      #3 rst_n = 1'b0;
      #1;
      chk("arst.valid", {31'd0, o_inst_valid}, 32'd0);
      chk("arst.addr", o_imem_addr, 32'h0);
      chk("arst.inst", o_inst, 32'h0);
      chk("arst.pc", o_inst_pc, 32'h0);
      #20;
      chk("arst.hold", {31'd0, o_inst_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
